// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   N_REQ             - number of requesters sharing the mux datapath
//   src_idx_t         - requester index type (also used for the last-grant pointer)
//   RESET_PTR_DEFAULT - pointer value after reset; 3 gives requester 0 top priority
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef logic [1:0] src_idx_t;

    localparam src_idx_t RESET_PTR_DEFAULT = 2'd3;

endpackage

// File: rtl/mux_4_1.sv
// Plain 4-bit 4:1 combinational multiplexer.
//   sel    in  2  select (0..3)
//   d0..d3 in  4  data inputs
//   y      out 4  selected data
module mux_4_1 (
    input  logic [1:0] sel,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] y
);

    always_comb begin
        y = d0;
        unique case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit 4:1 mux between four requesters, feeding a
// one-entry registered output stage with a valid/ready handshake.
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   req_valid  in   4      per-requester valid
//   req_data0..3 in WIDTH  per-requester data
//   req_ready  out  4      one-hot (or 0) accept strobe for the granted requester
//   out_valid  out  1      output register holds a word
//   out_ready  in   1      downstream accepts the output word
//   out_data   out  WIDTH  registered selected word
//   out_src    out  2      requester index that produced out_data
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter src_idx_t    RESET_PTR = RESET_PTR_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    src_idx_t         out_src_q;
    src_idx_t         ptr_q;

    logic             acc_en;
    logic             accept;
    logic             found;
    src_idx_t         grant_idx;
    src_idx_t         cand;
    logic [WIDTH-1:0] mux_y;

    // Output slot can take a word when empty or when it is being drained this cycle.
    assign acc_en = !out_valid_q | out_ready;
    assign accept = acc_en & (|req_valid);

    // Scan ptr+1 .. ptr+4 (mod 4); 2-bit arithmetic provides the wrap-around.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr_q + 2'd1 + src_idx_t'(k);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = accept & (grant_idx == src_idx_t'(i));
        end
    end

    mux_4_1 u_mux (
        .sel (grant_idx),
        .d0  (req_data0),
        .d1  (req_data1),
        .d2  (req_data2),
        .d3  (req_data3),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= RESET_PTR;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_y;
            out_src_q   <= grant_idx;
            ptr_q       <= grant_idx;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
